instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Control unit for the 4-bit TD4 core: fetches 8-bit instructions from the program ROM, decodes them, and sequences the shared datapath. It drives the 2-bit source select of the four-input data selector (register A, register B, input port, zero), supplies the immediate to the adder, and strobes the A/B/OUT register loads. It holds the program counter and carry flag, and provides run and single-step control.

## Interface
- `addrWidth`, 4, PC and ROM address width; program size is 2^addrWidth.
- `dataWidth`, 4, immediate and datapath width; instruction width is 4 + dataWidth.
- `CLK`  in  1  single clock, all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `RUN`  in  1  level; while high, instructions execute back-to-back.
- `STEP`  in  1  one-cycle pulse; executes exactly one instruction when idle.
- `ROM_ADDR`  out  addrWidth  equals PC; ROM is combinational.
- `ROM_DATA`  in  4+dataWidth  [7:4] opcode, [3:0] immediate.
- `CARRY`  in  1  adder carry-out for the current instruction.
- `SEL`  out  2  selector source: 0=A, 1=B, 2=IN, 3=zero.
- `IMM`  out  dataWidth  immediate field of IR, passed unmodified.
- `LOAD_A`, `LOAD_B`, `LOAD_OUT`  out  1 each  single-cycle register load strobes.
- `C_FLAG`  out  1  registered carry flag.
- `BUSY`  out  1  high in FETCH and EXEC.
- `RETIRE`  out  1  one-cycle pulse in EXEC of every instruction.
- `ILLEGAL`  out  1  one-cycle pulse in EXEC when the opcode is undefined.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- IDLE: go to FETCH if `RUN` is high, or if `STEP` is high. `STEP` is accepted only in IDLE and is never queued.
- FETCH: IR <= `ROM_DATA`, then go to EXEC.
- EXEC: strobes are decoded from IR. C_FLAG <= `CARRY` on every instruction, including jumps. Next PC is the jump target or PC+1, wrapping from 15 to 0. Then go to FETCH if `RUN` is high, otherwise IDLE.
- Opcode decode, as (SEL, load):
  - 0000 ADD A,Im: (0, A)
  - 0101 ADD B,Im: (1, B)
  - 0011 MOV A,Im: (3, A)
  - 0111 MOV B,Im: (3, B)
  - 0001 MOV A,B: (1, A)
  - 0100 MOV B,A: (0, B)
  - 0010 IN A: (2, A)
  - 0110 IN B: (2, B)
  - 1001 OUT B: (1, OUT)
  - 1011 OUT Im: (3, OUT)
  - 1111 JMP Im: PC <= Im
  - 1110 JNC Im: PC <= Im if C_FLAG==0, else PC+1
- Undefined opcodes execute as NOP: PC+1, no load, C_FLAG still updated, `ILLEGAL` pulses.
- Outside EXEC: `SEL`=3, all loads low, `RETIRE` and `ILLEGAL` low.

## Timing
- Each instruction takes 2 cycles (FETCH, EXEC). Continuous RUN gives 1 instruction per 2 clocks.
- All load strobes, `RETIRE`, and `ILLEGAL` are high for exactly the EXEC cycle. The datapath captures on the edge ending EXEC.
- JNC tests C_FLAG as it stood before the current EXEC, i.e. the carry from the previous instruction.
- `RUN` falling during FETCH or EXEC: the current instruction completes, then the FSM enters IDLE. No partial instruction occurs.
- `RUN` and `STEP` high together in IDLE: behaves as RUN.
- Reset values: state=IDLE, PC=0, IR=0, C_FLAG=0. Outputs after reset: `ROM_ADDR`=0, `SEL`=3, all strobes low, `BUSY`=0.
- Reset during EXEC: all strobes are gated low in that cycle (qualified with !`RST`), so no register loads. PC and C_FLAG take their reset values, not the jump or carry result.

## Structure
- Shared package `td4_isa`: opcode constants, SEL encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO), FSM state encoding.
- Sub-module `InstructionDecoder`: combinational. Maps opcode and C_FLAG to SEL, the three load enables, jump-taken, and illegal.
- Top level holds the FSM, PC, IR, C_FLAG, and output gating.

## Test plan
- Reset: assert `RST` 2 cycles -> PC=0, `SEL`=3, `LOAD_*`=0, `C_FLAG`=0, `BUSY`=0.
- STEP, ROM[0]=8'h35 -> EXEC cycle shows `SEL`=3, `IMM`=5, `LOAD_A`=1 for one cycle, `RETIRE`=1. Then PC=1 and IDLE. A second `STEP` pulse while `BUSY` is ignored.
- RUN, ROM[0]=8'h01 (ADD A,1) with `CARRY`=1, ROM[1]=8'hE0 (JNC 0) -> `C_FLAG`=1, JNC not taken, PC=2. Repeat with `CARRY`=0 at ROM[0] -> PC returns to 0.
- ROM[0]=8'hFF (JMP 15), ROM[15]=8'h90 (OUT B) -> PC=15, then `SEL`=1 with `LOAD_OUT`=1, then PC wraps to 0.
- Undefined opcode 8'h80 -> `ILLEGAL` pulses, no loads, PC+1.
- Drop `RUN` during FETCH -> EXEC completes with exactly one `RETIRE`, then IDLE. Assert `RST` during EXEC of MOV A,Im -> `LOAD_A` stays 0, PC=0 next cycle.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// TD4 instruction set definitions shared by the sequencer and its decoder:
// opcodes, data-selector source encodings and the control FSM state encoding.
package td4_isa;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_IN   = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

endpackage

// File: rtl/instruction_sequencer_decoder.sv
// Combinational opcode decode: selector source, register load enables,
// jump-taken and illegal-opcode flag. Undefined opcodes decode as NOP.
module InstructionDecoder
    import td4_isa::*;
(
    input  logic [3:0] opcode_i,
    input  logic       c_flag_i,
    output logic [1:0] sel_o,
    output logic       load_a_o,
    output logic       load_b_o,
    output logic       load_out_o,
    output logic       jump_o,
    output logic       illegal_o
);

    always_comb begin
        sel_o      = SEL_ZERO;
        load_a_o   = 1'b0;
        load_b_o   = 1'b0;
        load_out_o = 1'b0;
        jump_o     = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_i)
            OP_ADD_A:  begin sel_o = SEL_A;    load_a_o   = 1'b1; end
            OP_ADD_B:  begin sel_o = SEL_B;    load_b_o   = 1'b1; end
            OP_MOV_AI: begin sel_o = SEL_ZERO; load_a_o   = 1'b1; end
            OP_MOV_BI: begin sel_o = SEL_ZERO; load_b_o   = 1'b1; end
            OP_MOV_AB: begin sel_o = SEL_B;    load_a_o   = 1'b1; end
            OP_MOV_BA: begin sel_o = SEL_A;    load_b_o   = 1'b1; end
            OP_IN_A:   begin sel_o = SEL_IN;   load_a_o   = 1'b1; end
            OP_IN_B:   begin sel_o = SEL_IN;   load_b_o   = 1'b1; end
            OP_OUT_B:  begin sel_o = SEL_B;    load_out_o = 1'b1; end
            OP_OUT_I:  begin sel_o = SEL_ZERO; load_out_o = 1'b1; end
            OP_JMP:    jump_o = 1'b1;
            // JNC sees the carry left by the previous instruction
            OP_JNC:    jump_o = ~c_flag_i;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// TD4 control unit: FETCH/EXEC sequencing, PC, IR and carry flag, with
// run/single-step control. Datapath strobes are only ever live in EXEC.
module instruction_sequencer
    import td4_isa::*;
#(
    parameter int addrWidth = 4,
    parameter int dataWidth = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RUN,
    input  logic                   STEP,
    output logic [addrWidth-1:0]   ROM_ADDR,
    input  logic [dataWidth+3:0]   ROM_DATA,
    input  logic                   CARRY,
    output logic [1:0]             SEL,
    output logic [dataWidth-1:0]   IMM,
    output logic                   LOAD_A,
    output logic                   LOAD_B,
    output logic                   LOAD_OUT,
    output logic                   C_FLAG,
    output logic                   BUSY,
    output logic                   RETIRE,
    output logic                   ILLEGAL
);

    state_t                 state_q, state_d;
    logic [addrWidth-1:0]   pc_q, pc_d;
    logic [dataWidth+3:0]   ir_q, ir_d;
    logic                   c_flag_q, c_flag_d;

    logic [1:0]             dec_sel;
    logic                   dec_load_a, dec_load_b, dec_load_out;
    logic                   dec_jump, dec_illegal;
    logic                   exec_live;

    InstructionDecoder u_dec (
        .opcode_i   (ir_q[dataWidth+3:dataWidth]),
        .c_flag_i   (c_flag_q),
        .sel_o      (dec_sel),
        .load_a_o   (dec_load_a),
        .load_b_o   (dec_load_b),
        .load_out_o (dec_load_out),
        .jump_o     (dec_jump),
        .illegal_o  (dec_illegal)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        c_flag_d = c_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (RUN || STEP) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = ROM_DATA;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                c_flag_d = CARRY;
                pc_d     = dec_jump ? addrWidth'(ir_q[dataWidth-1:0])
                                    : pc_q + {{(addrWidth-1){1'b0}}, 1'b1};
                state_d  = RUN ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            c_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            c_flag_q <= c_flag_d;
        end
    end

    // Reset arriving mid-EXEC must not let the datapath capture anything
    assign exec_live = (state_q == ST_EXEC) && !RST;

    assign ROM_ADDR = pc_q;
    assign IMM      = ir_q[dataWidth-1:0];
    assign SEL      = exec_live ? dec_sel : SEL_ZERO;
    assign LOAD_A   = exec_live & dec_load_a;
    assign LOAD_B   = exec_live & dec_load_b;
    assign LOAD_OUT = exec_live & dec_load_out;
    assign RETIRE   = exec_live;
    assign ILLEGAL  = exec_live & dec_illegal;
    assign C_FLAG   = c_flag_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a combinational program ROM.
module tb_instruction_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RUN = 1'b0;
    logic       STEP = 1'b0;
    logic [3:0] ROM_ADDR;
    logic [7:0] ROM_DATA;
    logic       CARRY = 1'b0;
    logic [1:0] SEL;
    logic [3:0] IMM;
    logic       LOAD_A, LOAD_B, LOAD_OUT, C_FLAG, BUSY, RETIRE, ILLEGAL;

    logic [7:0] rom [16];
    int         errs = 0;
    int         checks = 0;

    assign ROM_DATA = rom[ROM_ADDR];

    instruction_sequencer #(.addrWidth(4), .dataWidth(4)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP),
        .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .CARRY(CARRY),
        .SEL(SEL), .IMM(IMM), .LOAD_A(LOAD_A), .LOAD_B(LOAD_B),
        .LOAD_OUT(LOAD_OUT), .C_FLAG(C_FLAG), .BUSY(BUSY),
        .RETIRE(RETIRE), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; RUN = 1'b0; STEP = 1'b0;
        tick(); tick();
        RST = 1'b0;
    endtask

    // Expected EXEC outputs for a short straight-line program
    logic [7:0] prog_ins [3] = '{8'h13, 8'h60, 8'h4C};
    logic [1:0] prog_sel [3] = '{2'd1, 2'd2, 2'd0};
    logic [2:0] prog_ld  [3] = '{3'b100, 3'b010, 3'b010};

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;

        // Reset state
        do_reset();
        chk("rst_pc", ROM_ADDR, 0);
        chk("rst_sel", SEL, 3);
        chk("rst_loads", {LOAD_A, LOAD_B, LOAD_OUT}, 0);
        chk("rst_cflag", C_FLAG, 0);
        chk("rst_busy", BUSY, 0);

        // Single step of MOV A,5; extra STEP while busy is ignored
        rom[0] = 8'h35;
        STEP = 1'b1;
        tick();
        chk("stp_fetch_busy", BUSY, 1);
        chk("stp_fetch_loada", LOAD_A, 0);
        tick();
        chk("stp_exec_sel", SEL, 3);
        chk("stp_exec_imm", IMM, 5);
        chk("stp_exec_loads", {LOAD_A, LOAD_B, LOAD_OUT}, 3'b100);
        chk("stp_exec_retire", RETIRE, 1);
        tick();
        STEP = 1'b0;
        chk("stp_idle_pc", ROM_ADDR, 1);
        chk("stp_idle_busy", BUSY, 0);
        chk("stp_idle_loada", LOAD_A, 0);
        tick();
        chk("stp_noqueue_busy", BUSY, 0);
        chk("stp_noqueue_pc", ROM_ADDR, 1);

        // ADD A,1 with carry, then JNC 0 not taken
        do_reset();
        rom[0] = 8'h01; rom[1] = 8'hE0;
        CARRY = 1'b1; RUN = 1'b1;
        tick(); tick();
        chk("add_sel", SEL, 0);
        chk("add_loada", LOAD_A, 1);
        tick();
        CARRY = 1'b0;
        chk("add_cflag", C_FLAG, 1);
        chk("jnc_fetch_pc", ROM_ADDR, 1);
        tick();
        RUN = 1'b0;
        chk("jnc_retire", RETIRE, 1);
        chk("jnc_loads", {LOAD_A, LOAD_B, LOAD_OUT}, 0);
        tick();
        chk("jnc_nt_pc", ROM_ADDR, 2);
        chk("jnc_cflag_upd", C_FLAG, 0);

        // Same with no carry: JNC taken
        do_reset();
        CARRY = 1'b0; RUN = 1'b1;
        tick(); tick(); tick();
        chk("jnc2_cflag", C_FLAG, 0);
        tick();
        RUN = 1'b0;
        tick();
        chk("jnc_taken_pc", ROM_ADDR, 0);

        // JMP 15, OUT B at 15, PC wraps
        do_reset();
        rom[0] = 8'hFF; rom[15] = 8'h90;
        RUN = 1'b1;
        tick(); tick();
        chk("jmp_retire", RETIRE, 1);
        tick();
        chk("jmp_pc", ROM_ADDR, 15);
        tick();
        RUN = 1'b0;
        chk("outb_sel", SEL, 1);
        chk("outb_loads", {LOAD_A, LOAD_B, LOAD_OUT}, 3'b001);
        tick();
        chk("wrap_pc", ROM_ADDR, 0);

        // Undefined opcode
        do_reset();
        rom[0] = 8'h80;
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
        tick();
        chk("ill_pulse", ILLEGAL, 1);
        chk("ill_loads", {LOAD_A, LOAD_B, LOAD_OUT}, 0);
        chk("ill_retire", RETIRE, 1);
        tick();
        chk("ill_pc", ROM_ADDR, 1);
        chk("ill_low", ILLEGAL, 0);

        // Back-to-back register moves and input
        do_reset();
        for (int i = 0; i < 3; i++) rom[i] = prog_ins[i];
        RUN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("prog%0d_fetch_ret", i), RETIRE, 0);
            tick();
            if (i == 2) RUN = 1'b0;
            chk($sformatf("prog%0d_sel", i), SEL, prog_sel[i]);
            chk($sformatf("prog%0d_loads", i), {LOAD_A, LOAD_B, LOAD_OUT}, prog_ld[i]);
        end
        tick();
        chk("prog_end_pc", ROM_ADDR, 3);

        // RUN drops during FETCH: instruction still completes once
        do_reset();
        rom[0] = 8'h7A;
        RUN = 1'b1;
        tick();
        RUN = 1'b0;
        tick();
        chk("drop_retire", RETIRE, 1);
        chk("drop_loadb", LOAD_B, 1);
        chk("drop_imm", IMM, 4'hA);
        tick();
        chk("drop_idle_ret", RETIRE, 0);
        chk("drop_idle_busy", BUSY, 0);
        tick();
        chk("drop_stay_pc", ROM_ADDR, 1);

        // Reset in EXEC of MOV A,Im gates strobes and discards PC/carry updates
        do_reset();
        rom[0] = 8'h35;
        RUN = 1'b1; CARRY = 1'b1;
        tick(); tick();
        RST = 1'b1;
        #1;
        chk("rstx_loada", LOAD_A, 0);
        chk("rstx_retire", RETIRE, 0);
        tick();
        chk("rstx_pc", ROM_ADDR, 0);
        chk("rstx_cflag", C_FLAG, 0);
        chk("rstx_busy", BUSY, 0);
        RST = 1'b0; RUN = 1'b0; CARRY = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
